// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered read data, programmable almost flags,
// synchronous flush, sticky overflow/underflow capture and a high-watermark register.
module sync_fifo_flags #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow,
  output logic [CNT_W-1:0]  max_count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  max_count_q, max_count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc, ovf_evt, unf_evt;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));

  // Flush swallows the requests of its cycle, so they neither transfer nor flag errors.
  always_comb begin
    wr_acc  = wr_en && !full  && !flush;
    rd_acc  = rd_en && !empty && !flush;
    ovf_evt = wr_en && full   && !flush;
    unf_evt = rd_en && empty  && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        dout_d   = mem[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    // A fresh error event wins over a simultaneous clear.
    overflow_d  = (clr_err ? 1'b0 : overflow_q)  | ovf_evt;
    underflow_d = (clr_err ? 1'b0 : underflow_q) | unf_evt;

    if (clr_err || (count_d > max_count_q)) max_count_d = count_d;
    else                                    max_count_d = max_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      max_count_q <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      max_count_q <= max_count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q] <= din;
  end

  assign dout      = dout_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign max_count = max_count_q;
endmodule
